// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port and the unified memory port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic            if_req_i;
    logic [XLEN-1:0] if_addr_i;
    logic            if_gnt_o;
    logic            if_rvalid_o;
    logic [XLEN-1:0] if_rdata_o;

    logic            d_req_i;
    logic            d_we_i;
    logic [XLEN-1:0] d_addr_i;
    logic [XLEN-1:0] d_wdata_i;
    logic            d_gnt_o;
    logic            d_rvalid_o;
    logic [XLEN-1:0] d_rdata_o;

    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output mem_addr_o, mem_wdata_o, mem_we_o,
        input  mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  mem_addr_o, mem_wdata_o, mem_we_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single synchronous-read memory.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating arbitration; otherwise data has fixed priority.
module mem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    mem_arbiter_if.slave  bus
);

    localparam logic [XLEN-1:0] ZERO = '0;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_gnt;
    logic   owner;
    logic   pick_data;
    logic   grant;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie the port that did not win last time takes the grant.
    assign pick_data = bus.d_req_i && (!bus.if_req_i || !last_gnt);
`else
    assign pick_data = bus.d_req_i;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            last_gnt <= 1'b0;
            owner    <= 1'b0;
        end else begin
            state <= state_next;
            if (grant) begin
                last_gnt <= pick_data;
                owner    <= pick_data;
            end else begin
                last_gnt <= last_gnt;
                owner    <= owner;
            end
        end
    end

    // Outputs are forced quiet while reset is held, even if requests are present.
    always_comb begin
        state_next      = state;
        grant           = 1'b0;
        bus.if_gnt_o    = 1'b0;
        bus.if_rvalid_o = 1'b0;
        bus.if_rdata_o  = ZERO;
        bus.d_gnt_o     = 1'b0;
        bus.d_rvalid_o  = 1'b0;
        bus.d_rdata_o   = ZERO;
        bus.mem_addr_o  = ZERO;
        bus.mem_wdata_o = ZERO;
        bus.mem_we_o    = 1'b0;

        if (rstn_i) begin
            case (state)
                IDLE: begin
                    if (bus.if_req_i || bus.d_req_i) begin
                        grant = 1'b1;
                        if (pick_data) begin
                            bus.d_gnt_o     = 1'b1;
                            bus.mem_addr_o  = bus.d_addr_i;
                            bus.mem_wdata_o = bus.d_wdata_i;
                            bus.mem_we_o    = bus.d_we_i;
                            if (!bus.d_we_i) begin
                                state_next = RESP;
                            end
                        end else begin
                            bus.if_gnt_o   = 1'b1;
                            bus.mem_addr_o = bus.if_addr_i;
                            state_next     = RESP;
                        end
                    end
                end
                RESP: begin
                    if (owner) begin
                        bus.d_rvalid_o = 1'b1;
                        bus.d_rdata_o  = bus.mem_rdata_i;
                    end else begin
                        bus.if_rvalid_o = 1'b1;
                        bus.if_rdata_o  = bus.mem_rdata_i;
                    end
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small synchronous-read memory model.
// Unwritten memory words read back as address ^ 32'h5A5A_0000.
module tb_mem_arbiter;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    mem_arbiter_if #(.XLEN(32)) bus ();

    mem_arbiter #(.XLEN(32)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] mem_store [logic [31:0]];

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if (mem_store.exists(addr)) return mem_store[addr];
        return addr ^ 32'h5A5A_0000;
    endfunction

    // Read data appears one cycle after the address; a write lands after the read sample.
    always @(posedge clk) begin
        bus.mem_rdata_i <= memWord(bus.mem_addr_o);
        if (bus.mem_we_o) mem_store[bus.mem_addr_o] = bus.mem_wdata_o;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic if_req, input logic [31:0] if_addr,
                                 input logic d_req, input logic d_we,
                                 input logic [31:0] d_addr, input logic [31:0] d_wdata);
        @(negedge clk);
        bus.if_req_i  = if_req;
        bus.if_addr_i = if_addr;
        bus.d_req_i   = d_req;
        bus.d_we_i    = d_we;
        bus.d_addr_i  = d_addr;
        bus.d_wdata_i = d_wdata;
    endtask

    logic [3:0] exp_dg;
    logic [3:0] exp_ig;

    initial begin
        checks          = 0;
        failures        = 0;
        rstn            = 1'b0;
        bus.mem_rdata_i = '0;
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = '0;
        bus.d_req_i     = 1'b0;
        bus.d_we_i      = 1'b0;
        bus.d_addr_i    = '0;
        bus.d_wdata_i   = '0;

        // Requests present during reset must not leak through.
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b1, 32'h30, 32'h1234);
        #1;
        checkOutput("rst_if_gnt", bus.if_gnt_o, 0);
        checkOutput("rst_d_gnt", bus.d_gnt_o, 0);
        checkOutput("rst_mem_addr", bus.mem_addr_o, 0);
        checkOutput("rst_mem_wdata", bus.mem_wdata_o, 0);
        checkOutput("rst_mem_we", bus.mem_we_o, 0);
        checkOutput("rst_rvalids", {bus.if_rvalid_o, bus.d_rvalid_o}, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rstn = 1'b1;

        // Fetch-only read of 0x10.
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("fetch_if_gnt", bus.if_gnt_o, 1);
        checkOutput("fetch_d_gnt", bus.d_gnt_o, 0);
        checkOutput("fetch_mem_addr", bus.mem_addr_o, 32'h10);
        checkOutput("fetch_mem_we", bus.mem_we_o, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("fetch_if_rvalid", bus.if_rvalid_o, 1);
        checkOutput("fetch_if_rdata", bus.if_rdata_o, 32'h5A5A_0010);
        checkOutput("fetch_d_rvalid", bus.d_rvalid_o, 0);
        checkOutput("fetch_d_rdata", bus.d_rdata_o, 0);
        checkOutput("fetch_resp_gnt", {bus.if_gnt_o, bus.d_gnt_o}, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("fetch_done_rvalid", bus.if_rvalid_o, 0);
        checkOutput("fetch_done_addr", bus.mem_addr_o, 0);

        // Back-to-back data writes.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'hCAFE_0000 + 32'(i));
            #1;
            checkOutput($sformatf("wr%0d_d_gnt", i), bus.d_gnt_o, 1);
            checkOutput($sformatf("wr%0d_mem_we", i), bus.mem_we_o, 1);
            checkOutput($sformatf("wr%0d_mem_addr", i), bus.mem_addr_o, 32'h100 + 32'(4 * i));
            checkOutput($sformatf("wr%0d_mem_wdata", i), bus.mem_wdata_o, 32'hCAFE_0000 + 32'(i));
            checkOutput($sformatf("wr%0d_d_rvalid", i), bus.d_rvalid_o, 0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("wr_after_d_rvalid", bus.d_rvalid_o, 0);
        checkOutput("wr_after_mem_we", bus.mem_we_o, 0);

        // Data read-back of the middle write.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h104, 32'h0);
        #1;
        checkOutput("rd104_d_gnt", bus.d_gnt_o, 1);
        checkOutput("rd104_mem_we", bus.mem_we_o, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("rd104_d_rvalid", bus.d_rvalid_o, 1);
        checkOutput("rd104_d_rdata", bus.d_rdata_o, 32'hCAFE_0001);
        checkOutput("rd104_if_rdata", bus.if_rdata_o, 0);

        // Simultaneous reads held for four cycles, starting from last_gnt = 0.
        @(negedge clk);
        rstn = 1'b0;
        #1;
        rstn = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_dg = 4'b0001;
        exp_ig = 4'b0100;
`else
        exp_dg = 4'b0101;
        exp_ig = 4'b0000;
`endif
        for (int c = 0; c < 4; c++) begin
            if (c == 0) applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 32'h30, 32'h0);
            else @(negedge clk);
            #1;
            checkOutput($sformatf("sim_c%0d_d_gnt", c), bus.d_gnt_o, exp_dg[c]);
            checkOutput($sformatf("sim_c%0d_if_gnt", c), bus.if_gnt_o, exp_ig[c]);
            if (c == 1) begin
                checkOutput("sim_c1_d_rvalid", bus.d_rvalid_o, 1);
                checkOutput("sim_c1_d_rdata", bus.d_rdata_o, 32'h5A5A_0030);
            end
            if (c == 3) begin
                checkOutput("sim_c3_d_rvalid", bus.d_rvalid_o, exp_dg[2]);
                checkOutput("sim_c3_if_rvalid", bus.if_rvalid_o, exp_ig[2]);
                checkOutput("sim_c3_rdata", bus.d_rdata_o | bus.if_rdata_o,
                            exp_ig[2] ? 32'h5A5A_0020 : 32'h5A5A_0030);
            end
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset pulse during RESP aborts the pending fetch response.
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("abort_if_gnt", bus.if_gnt_o, 1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("abort_pre_rvalid", bus.if_rvalid_o, 1);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("abort_in_rst_rvalid", {bus.if_rvalid_o, bus.d_rvalid_o}, 0);
        checkOutput("abort_in_rst_rdata", bus.if_rdata_o, 0);
        #1;
        rstn = 1'b1;
        #1;
        checkOutput("abort_release_rvalid", bus.if_rvalid_o, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("abort_next_rvalid", {bus.if_rvalid_o, bus.d_rvalid_o}, 0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h104, 32'h0);
        #1;
        checkOutput("abort_after_d_gnt", bus.d_gnt_o, 1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("abort_after_d_rvalid", bus.d_rvalid_o, 1);
        checkOutput("abort_after_d_rdata", bus.d_rdata_o, 32'hCAFE_0001);

        // A request arriving during RESP waits for the next IDLE cycle.
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("late_if_gnt", bus.if_gnt_o, 1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        #1;
        checkOutput("late_resp_gnts", {bus.if_gnt_o, bus.d_gnt_o}, 0);
        checkOutput("late_resp_if_rvalid", bus.if_rvalid_o, 1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        #1;
        checkOutput("late_d_gnt", bus.d_gnt_o, 1);
        checkOutput("late_mem_addr", bus.mem_addr_o, 32'h40);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("late_d_rvalid", bus.d_rvalid_o, 1);
        checkOutput("late_d_rdata", bus.d_rdata_o, 32'h5A5A_0040);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL take parameter XLEN, default 32, giving the address and data width.
REQ-002 The block SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rstn_i, input, 1 bit, the reset: asynchronous, active-low.
REQ-004 The block SHALL have ports if_req_i, input, 1 bit, and if_addr_i, input, XLEN bits: the instruction-fetch read request and its address.
REQ-005 The block SHALL have ports if_gnt_o, output, 1 bit; if_rvalid_o, output, 1 bit; and if_rdata_o, output, XLEN bits: fetch grant, fetch response valid, and fetch read data.
REQ-006 The block SHALL have ports d_req_i, input, 1 bit; d_we_i, input, 1 bit; d_addr_i, input, XLEN bits; and d_wdata_i, input, XLEN bits: the data request, write enable, address and write data.
REQ-007 The block SHALL have ports d_gnt_o, output, 1 bit; d_rvalid_o, output, 1 bit; and d_rdata_o, output, XLEN bits: data grant, data read-response valid, and data read data.
REQ-008 The block SHALL have ports mem_addr_o, output, XLEN bits; mem_wdata_o, output, XLEN bits; mem_we_o, output, 1 bit; and mem_rdata_i, input, XLEN bits: the unified memory port (synchronous read, one-cycle latency).

Function
REQ-009 The block SHALL implement FSM states IDLE and RESP, plus a 1-bit register last_gnt (0 = fetch, 1 = data).
- IDLE: the block SHALL grant when any request is present.
- RESP: the block SHALL issue no grant, hold the owner's rvalid high, and pass mem_rdata_i to that owner's rdata port.
REQ-010 A grant SHALL be combinational in IDLE: exactly one of if_gnt_o/d_gnt_o is high in the same cycle as the winning request; the request is accepted on that clock edge.
- In the grant cycle, mem_addr_o/mem_wdata_o/mem_we_o SHALL be driven from the winner.
- mem_we_o SHALL be high only for a granted data write.
REQ-011 A granted read SHALL move the FSM to RESP and record the owner. The rvalid SHALL be high for exactly the next cycle, and the FSM SHALL then return to IDLE, giving a read latency of 1 cycle after grant.
REQ-012 A granted write SHALL complete in the grant cycle with no rvalid; the FSM SHALL stay IDLE, allowing back-to-back writes every cycle.
REQ-013 Arbitration on simultaneous requests SHALL follow REQ-021. A single requester SHALL always win when alone.
REQ-014 last_gnt SHALL update on every grant to the granted port.
REQ-015 A requester SHALL hold req and its address/data stable until gnt; the block SHALL NOT latch unaccepted requests.
REQ-016 A request dropped before gnt SHALL be ignored without side effect.
REQ-017 When no grant is active, mem_addr_o, mem_wdata_o and mem_we_o SHALL be 0. Non-owner rdata ports SHALL be 0.
REQ-018 Addresses SHALL pass unmodified; alignment is the requester's responsibility.

Reset
REQ-019 While rstn_i is low:
- the FSM SHALL be IDLE and last_gnt SHALL be 0;
- all gnt, rvalid and mem_we_o outputs SHALL be 0;
- all data and address outputs SHALL be 0.
REQ-020 Reset asserted in RESP SHALL abort the response: no rvalid after reset release, and the outstanding read is discarded.

Configuration
REQ-021 Macro MEM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
- Defined: on simultaneous requests the port not equal to last_gnt wins (alternating).
- Undefined: fixed priority, data port always wins; last_gnt is still maintained but unused.

Verification
REQ-022 Reset, then fetch-only: if_req_i=1, if_addr_i=0x0000_0010 -> if_gnt_o=1 same cycle, mem_addr_o=0x10; next cycle if_rvalid_o=1, if_rdata_o=mem word at 0x10; then IDLE.
REQ-023 Data writes on 3 consecutive cycles to 0x100, 0x104, 0x108 -> d_gnt_o=1 and mem_we_o=1 each cycle, d_rvalid_o never 1.
REQ-024 Simultaneous fetch and data reads held 4 cycles, macro undefined -> data granted at cycles 0 and 2, fetch never granted.
- Macro defined, last_gnt=0 after reset -> data granted at cycle 0, fetch at cycle 2.
REQ-025 Read granted, rstn_i pulsed low during RESP -> rvalids 0, FSM IDLE, no rvalid after release; next request granted normally.
REQ-026 Request in RESP cycle -> both gnts 0 in RESP; grant occurs on the following IDLE cycle with correct winner.
